delay_line_probe: RTL
=====================

// Module: delay_line_probe
// PURPOSE
//  Measures the latency of a delay line: the receiving end of the 30/45/60/90-stage chains.
//  On start: drives zeros to flush the line, then injects one PATTERN word on probe_out.
//  Counts clocks until PATTERN appears on echo_in and reports the count, or a timeout.
//  Sits beside the delay-line bank: probe_out feeds the line input, echo_in takes the selected output.
// PARAMETERS
//  WIDTH      8      data width of probe_out / echo_in
//  CNT_W      8      width of counter and delay_count
//  MAX_DELAY  127    longest delay searched; must be < 2**CNT_W-1
//  PATTERN    8'hA5  probe word; must be nonzero
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst_n        in   1      synchronous reset, active low
//  start        in   1      one-cycle request; ignored while busy
//  echo_in      in   WIDTH  delay-line output under test
//  probe_out    out  WIDTH  delay-line input stimulus
//  busy         out  1      high from the cycle after start is accepted until the cycle before done
//  done         out  1      one-cycle pulse when a result is valid
//  timeout      out  1      sticky: last run found no match; cleared on next accepted start
//  delay_count  out  CNT_W  measured delay; held until next accepted start
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; probe_out=0, busy=0, done=0, timeout=0, delay_count=0, cnt=0.
//  Reset mid-run aborts immediately with the same values. There is no partial result.
//  FSM states: IDLE, FLUSH, SEND, WAIT, DONE.
//  IDLE: probe_out=0. When start=1: go to FLUSH, cnt<=0, timeout<=0, delay_count<=0.
//  FLUSH: probe_out=0 for exactly MAX_DELAY+1 cycles (cnt 0..MAX_DELAY), then go to SEND.
//  SEND: exactly 1 cycle, probe_out=PATTERN; this cycle is t0.
//   - If echo_in==PATTERN in this cycle (zero-delay path): delay_count<=0, go to DONE.
//   - Otherwise cnt<=1 and go to WAIT.
//  WAIT: probe_out=0. In cycle t0+k, cnt==k.
//   - If echo_in==PATTERN: delay_count<=cnt, go to DONE.
//   - Else if cnt==MAX_DELAY: timeout<=1, delay_count<=all-ones, go to DONE.
//   - Else cnt<=cnt+1.
//  DONE: 1 cycle, done=1, busy=0, then IDLE. start seen in DONE is ignored.
//  Net effect: an N-register line (N<=MAX_DELAY) reports delay_count=N.
//   Done is asserted in cycle t0+N+1.
//  If a match and cnt==MAX_DELAY happen in the same cycle, the match wins (no timeout).
//  Only an exact WIDTH-bit compare counts; any other nonzero echo is ignored.
//  cnt never wraps: its maximum value is MAX_DELAY.
//  busy=1 in FLUSH, SEND and WAIT; 0 otherwise.
//  All outputs are registered or decoded from state only. No combinational path from echo_in.
// STRUCTURE
//  Shared package delay_line_pkg holds:
//   - state encoding localparams (IDLE=0, FLUSH=1, SEND=2, WAIT=3, DONE=4)
//   - default PATTERN and CNT_W constants, also used by the top-level and the line modules.
//  Sub-module probe_counter: CNT_W-bit up-counter with clear, enable and a terminal flag (==MAX_DELAY).
//   It is shared by the FLUSH and WAIT phases. The FSM and compare stay in this module.
// TESTING
//  1. 30-stage register line, start pulse -> delay_count=30, timeout=0, done exactly at t0+31.
//  2. Repeat on the 45/60/90-stage lines -> delay_count = 45 / 60 / 90.
//  3. Direct wire echo_in=probe_out -> delay_count=0, done at t0+1.
//  4. 1-stage register line -> delay_count=1.
//  5. echo_in tied 0 -> timeout=1, delay_count=8'hFF, done at t0+MAX_DELAY+1; probe_out=0 afterwards.
//  6. Line preloaded with 8'hA5 junk -> flush clears it and the correct N is reported.
//  7. Start pulsed again while busy -> ignored, first result unchanged.
//  8. rst_n=0 during WAIT -> next cycle all outputs 0 and state IDLE.
//     A new start then measures correctly.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared constants and FSM state type for the delay-line probe and the line modules.
package delay_line_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_MAX_DELAY = 127;
    localparam logic [7:0]  DEF_PATTERN   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } probe_state_e;

endpackage

// File: rtl/delay_line_probe_if.sv
// Probe-side bundle: start request, line stimulus/echo and measurement results.
interface delay_line_probe_if
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             start;
    logic [WIDTH-1:0] echo_in;
    logic [WIDTH-1:0] probe_out;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] delay_count;

    modport master (
        output start,
        output echo_in,
        input  probe_out,
        input  busy,
        input  done,
        input  timeout,
        input  delay_count
    );

    modport slave (
        input  start,
        input  echo_in,
        output probe_out,
        output busy,
        output done,
        output timeout,
        output delay_count
    );

endinterface

// File: rtl/probe_counter.sv
// Saturating up-counter with synchronous clear and a terminal flag at MAX_VAL.
module probe_counter
    import delay_line_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MAX_VAL = DEF_MAX_DELAY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_VAL);

    assign term = (cnt == TERM_VAL);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en && !term) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/delay_line_probe.sv
// Delay-line latency probe: flush with zeros, inject PATTERN once, count clocks until it echoes.
module delay_line_probe
    import delay_line_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      CNT_W     = DEF_CNT_W,
    parameter int unsigned      MAX_DELAY = DEF_MAX_DELAY,
    parameter logic [WIDTH-1:0] PATTERN   = WIDTH'(DEF_PATTERN)
) (
    input logic               clk,
    input logic               rst_n,
    delay_line_probe_if.slave bus
);

    probe_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic             term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             match;

    assign match = (bus.echo_in == PATTERN);

    // Clearing at the end of FLUSH and stepping in SEND lands cnt at 1 on the first WAIT cycle.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state)
            IDLE:    cnt_clr = 1'b1;
            FLUSH:   if (term) cnt_clr = 1'b1; else cnt_en = 1'b1;
            SEND:    cnt_en = 1'b1;
            WAIT:    cnt_en = !match;
            default: cnt_clr = 1'b1;
        endcase
    end

    probe_counter #(
        .CNT_W  (CNT_W),
        .MAX_VAL(MAX_DELAY)
    ) u_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .term (term)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.probe_out   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.delay_count <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.probe_out <= '0;
                    if (bus.start) begin
                        state           <= FLUSH;
                        bus.busy        <= 1'b1;
                        bus.timeout     <= 1'b0;
                        bus.delay_count <= '0;
                    end
                end
                FLUSH: begin
                    if (term) begin
                        state         <= SEND;
                        bus.probe_out <= PATTERN;
                    end
                end
                SEND: begin
                    bus.probe_out <= '0;
                    if (match) begin
                        state           <= DONE;
                        bus.delay_count <= '0;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A match on the last searched cycle still counts as a result.
                    if (match) begin
                        state           <= DONE;
                        bus.delay_count <= cnt;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                    end else if (term) begin
                        state           <= DONE;
                        bus.timeout     <= 1'b1;
                        bus.delay_count <= '1;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    bus.probe_out <= '0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
